// File: rtl/dsp_rd_order_ctrl_pkg.sv
// Shared types and defaults for the per-master read-order controller.
package dsp_rd_order_ctrl_pkg;

  localparam int AXI_LEN_W       = 8;
  localparam int DSP_OUTST_DEPTH = 8;
  localparam int DSP_SLV_AMT     = 2;
  localparam int DSP_SLV_ID_W    = $clog2(DSP_SLV_AMT);

  // One in-order queue entry; len is only stored when beat checking is built in.
  typedef struct packed {
    logic [DSP_SLV_ID_W-1:0] slv_id;
    logic [AXI_LEN_W-1:0]    len;
  } dsp_ord_ent_t;

  function automatic int dsp_ent_w(input int slv_id_w, input int len_w, input bit with_len);
    return with_len ? (slv_id_w + len_w) : slv_id_w;
  endfunction

endpackage

// File: rtl/dsp_rd_order_ctrl_if.sv
// AR/R observation bus between the master-side AR path, the RDATA dispatcher and the order controller.
interface dsp_rd_order_ctrl_if
  import dsp_rd_order_ctrl_pkg::*;
#(
  parameter int SLV_AMT  = DSP_SLV_AMT,
  parameter int SLV_ID_W = $clog2(SLV_AMT),
  parameter int CNT_W    = $clog2(DSP_OUTST_DEPTH) + 1,
  parameter int LEN_W    = AXI_LEN_W
);
  logic                m_ARVALID_i;
  logic [LEN_W-1:0]    m_ARLEN_i;
  logic [SLV_ID_W-1:0] ar_slv_id_i;
  logic                m_ARREADY_o;
  logic [SLV_AMT-1:0]  sa_ARVALID_o;
  logic [SLV_AMT-1:0]  sa_ARREADY_i;
  logic                m_RVALID_i;
  logic                m_RREADY_i;
  logic                m_RLAST_i;
  logic [SLV_ID_W-1:0] dsp_AR_slv_id_o;
  logic                dsp_AR_disable_o;
  logic [CNT_W-1:0]    outst_cnt_o;
  logic                rlast_err_o;

  modport master (
    output m_ARVALID_i, m_ARLEN_i, ar_slv_id_i, sa_ARREADY_i,
    output m_RVALID_i, m_RREADY_i, m_RLAST_i,
    input  m_ARREADY_o, sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o,
    input  outst_cnt_o, rlast_err_o
  );

  modport slave (
    input  m_ARVALID_i, m_ARLEN_i, ar_slv_id_i, sa_ARREADY_i,
    input  m_RVALID_i, m_RREADY_i, m_RLAST_i,
    output m_ARREADY_o, sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o,
    output outst_cnt_o, rlast_err_o
  );
endinterface

// File: rtl/dsp_rd_order_ctrl_fifo.sv
// Generic show-ahead FIFO: head visible on rd_dat whenever rd_vld; one-cycle write-to-read latency.
// Writes are dropped while full (wr_rdy=0), reads ignored while empty.
module dsp_rd_order_ctrl_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_vld,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  wr_rdy,
  input  logic                  rd_rdy,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_dat
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  push;
  logic                  pop;

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign rd_vld = (wr_ptr != rd_ptr);
  assign wr_rdy = (wr_ptr[AW-1:0] != rd_ptr[AW-1:0]) || (wr_ptr[AW] == rd_ptr[AW]);
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/dsp_rd_order_ctrl.sv
// Read-order controller: queues the target slave of each accepted AR and steers the R dispatcher in issue order;
// head valid one cycle after push/pop. AR stalls at OUTST_DEPTH outstanding. DSP_RD_BEAT_CHECK_EN adds ARLEN/RLAST checking.
module dsp_rd_order_ctrl
  import dsp_rd_order_ctrl_pkg::*;
#(
  parameter int SLV_AMT     = DSP_SLV_AMT,
  parameter int SLV_ID_W    = $clog2(SLV_AMT),
  parameter int OUTST_DEPTH = DSP_OUTST_DEPTH,
  parameter int CNT_W       = $clog2(OUTST_DEPTH) + 1,
  parameter int LEN_W       = AXI_LEN_W
) (
  input  logic                ACLK_i,
  input  logic                ARESETn_i,
  dsp_rd_order_ctrl_if.slave  bus
);
`ifdef DSP_RD_BEAT_CHECK_EN
  localparam bit WITH_LEN = 1'b1;
`else
  localparam bit WITH_LEN = 1'b0;
`endif
  localparam int ENT_W = dsp_ent_w(SLV_ID_W, LEN_W, WITH_LEN);

  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             head_vld;
  logic             fifo_wr_rdy;
  logic             ar_hs;
  logic             pop;
  logic [ENT_W-1:0] wr_ent;
  logic [ENT_W-1:0] head_ent;

  // AR gating depends only on the registered count, never on R inputs.
  assign full             = (cnt == CNT_W'(OUTST_DEPTH));
  assign bus.m_ARREADY_o  = bus.sa_ARREADY_i[bus.ar_slv_id_i] & ~full;
  assign ar_hs            = bus.m_ARVALID_i & bus.m_ARREADY_o;
  assign empty            = ~head_vld;
  assign pop              = bus.m_RVALID_i & bus.m_RREADY_i & bus.m_RLAST_i & ~empty;

  always_comb begin
    bus.sa_ARVALID_o = '0;
    for (int k = 0; k < SLV_AMT; k++) begin
      bus.sa_ARVALID_o[k] = bus.m_ARVALID_i & ~full & (bus.ar_slv_id_i == SLV_ID_W'(k));
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      cnt <= '0;
    end else if (ar_hs && !pop) begin
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !ar_hs) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef DSP_RD_BEAT_CHECK_EN
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] head_len;
  logic             r_hs;
  logic             err_q;

  assign wr_ent   = {bus.ar_slv_id_i, bus.m_ARLEN_i};
  assign head_len = head_ent[LEN_W-1:0];
  assign r_hs     = bus.m_RVALID_i & bus.m_RREADY_i & ~empty;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (r_hs) begin
      if (bus.m_RLAST_i) begin
        beat_cnt <= '0;
        if (beat_cnt != head_len) err_q <= 1'b1;
      end else begin
        beat_cnt <= beat_cnt + LEN_W'(1);
        if (beat_cnt == head_len) err_q <= 1'b1;
      end
    end
  end

  assign bus.rlast_err_o = err_q;
`else
  assign wr_ent          = bus.ar_slv_id_i;
  assign bus.rlast_err_o = 1'b0;
`endif

  dsp_rd_order_ctrl_fifo #(
    .DATA_WIDTH (ENT_W),
    .FIFO_DEPTH (OUTST_DEPTH)
  ) u_ord_fifo (
    .clk    (ACLK_i),
    .rst_n  (ARESETn_i),
    .wr_vld (ar_hs),
    .wr_dat (wr_ent),
    .wr_rdy (fifo_wr_rdy),
    .rd_rdy (pop),
    .rd_vld (head_vld),
    .rd_dat (head_ent)
  );

  // Queue storage is not reset, so the id is forced to 0 while nothing is outstanding.
  assign bus.dsp_AR_slv_id_o  = empty ? '0 : head_ent[ENT_W-1 -: SLV_ID_W];
  assign bus.dsp_AR_disable_o = empty;
  assign bus.outst_cnt_o      = cnt;

endmodule

// File: tb/tb_dsp_rd_order_ctrl.sv
// Directed bench for dsp_rd_order_ctrl: ordering, full/empty limits, wrap, async reset and beat checking.
module tb_dsp_rd_order_ctrl;
  import dsp_rd_order_ctrl_pkg::*;

  localparam int SLV_AMT     = 2;
  localparam int SLV_ID_W    = 1;
  localparam int OUTST_DEPTH = 8;
  localparam int CNT_W       = 4;
  localparam int LEN_W       = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  dsp_rd_order_ctrl_if #(
    .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) bus ();

  dsp_rd_order_ctrl #(
    .SLV_AMT(SLV_AMT), .SLV_ID_W(SLV_ID_W), .OUTST_DEPTH(OUTST_DEPTH),
    .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK_i    (clk),
    .ARESETn_i (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ar_push(input logic [SLV_ID_W-1:0] id, input logic [LEN_W-1:0] len);
    bus.m_ARVALID_i = 1'b1;
    bus.ar_slv_id_i = id;
    bus.m_ARLEN_i   = len;
    tick();
    bus.m_ARVALID_i = 1'b0;
    settle();
  endtask

  task automatic r_beat(input logic last);
    bus.m_RVALID_i = 1'b1;
    bus.m_RREADY_i = 1'b1;
    bus.m_RLAST_i  = last;
    tick();
    bus.m_RVALID_i = 1'b0;
    bus.m_RREADY_i = 1'b0;
    bus.m_RLAST_i  = 1'b0;
    settle();
  endtask

  initial begin
    logic [SLV_ID_W-1:0] exp_id;

    bus.m_ARVALID_i  = 1'b0;
    bus.m_ARLEN_i    = '0;
    bus.ar_slv_id_i  = '0;
    bus.sa_ARREADY_i = '0;
    bus.m_RVALID_i   = 1'b0;
    bus.m_RREADY_i   = 1'b0;
    bus.m_RLAST_i    = 1'b0;
    #3;
    chk("rst_disable", 32'(bus.dsp_AR_disable_o), 32'd1);
    chk("rst_cnt",     32'(bus.outst_cnt_o),      32'd0);
    chk("rst_slv_id",  32'(bus.dsp_AR_slv_id_o),  32'd0);
    chk("rst_err",     32'(bus.rlast_err_o),      32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Idle: ARREADY follows the addressed slave's ready.
    bus.sa_ARREADY_i = 2'b10;
    bus.ar_slv_id_i  = 1'b1;
    settle();
    chk("idle_arrdy_s1", 32'(bus.m_ARREADY_o),  32'd1);
    chk("idle_sa_vld",   32'(bus.sa_ARVALID_o), 32'd0);
    bus.ar_slv_id_i  = 1'b0;
    settle();
    chk("idle_arrdy_s0", 32'(bus.m_ARREADY_o),      32'd0);
    chk("idle_disable",  32'(bus.dsp_AR_disable_o), 32'd1);
    bus.sa_ARREADY_i = 2'b11;

    // Single AR to slave 1, len 3, then 4 beats.
    bus.m_ARVALID_i = 1'b1;
    bus.ar_slv_id_i = 1'b1;
    bus.m_ARLEN_i   = 8'd3;
    settle();
    chk("t2_sa_vld",   32'(bus.sa_ARVALID_o),     32'h2);
    chk("t2_arrdy",    32'(bus.m_ARREADY_o),      32'd1);
    chk("t2_dis_pre",  32'(bus.dsp_AR_disable_o), 32'd1);
    tick();
    bus.m_ARVALID_i = 1'b0;
    settle();
    chk("t2_dis_post", 32'(bus.dsp_AR_disable_o), 32'd0);
    chk("t2_slv_id",   32'(bus.dsp_AR_slv_id_o),  32'd1);
    chk("t2_cnt",      32'(bus.outst_cnt_o),      32'd1);
    for (int i = 0; i < 3; i++) begin
      r_beat(1'b0);
      chk("t2_beat_id",  32'(bus.dsp_AR_slv_id_o),  32'd1);
      chk("t2_beat_dis", 32'(bus.dsp_AR_disable_o), 32'd0);
    end
    r_beat(1'b1);
    chk("t2_last_dis", 32'(bus.dsp_AR_disable_o), 32'd1);
    chk("t2_last_cnt", 32'(bus.outst_cnt_o),      32'd0);
    chk("t2_last_id",  32'(bus.dsp_AR_slv_id_o),  32'd0);

    // Back-to-back ARs to slaves 0,1,0.
    ar_push(1'b0, 8'd1);
    ar_push(1'b1, 8'd0);
    ar_push(1'b0, 8'd0);
    chk("t3_cnt3",  32'(bus.outst_cnt_o),     32'd3);
    chk("t3_head0", 32'(bus.dsp_AR_slv_id_o), 32'd0);
    r_beat(1'b0);
    chk("t3_nonlast_id",  32'(bus.dsp_AR_slv_id_o), 32'd0);
    chk("t3_nonlast_cnt", 32'(bus.outst_cnt_o),     32'd3);
    r_beat(1'b1);
    chk("t3_head1", 32'(bus.dsp_AR_slv_id_o), 32'd1);
    chk("t3_cnt2",  32'(bus.outst_cnt_o),     32'd2);
    r_beat(1'b1);
    chk("t3_head2", 32'(bus.dsp_AR_slv_id_o), 32'd0);
    chk("t3_cnt1",  32'(bus.outst_cnt_o),     32'd1);
    r_beat(1'b1);
    chk("t3_empty", 32'(bus.dsp_AR_disable_o), 32'd1);

    // Fill to the limit, then pop and a held 9th AR in the same cycle.
    for (int i = 0; i < 8; i++) ar_push(SLV_ID_W'(i % 2), 8'd0);
    chk("t4_cnt8", 32'(bus.outst_cnt_o), 32'd8);
    bus.m_ARVALID_i = 1'b1;
    bus.ar_slv_id_i = 1'b0;
    settle();
    chk("t4_full_arrdy", 32'(bus.m_ARREADY_o),  32'd0);
    chk("t4_full_sa",    32'(bus.sa_ARVALID_o), 32'd0);
    tick();
    chk("t4_held_cnt", 32'(bus.outst_cnt_o), 32'd8);
    bus.m_RVALID_i = 1'b1;
    bus.m_RREADY_i = 1'b1;
    bus.m_RLAST_i  = 1'b1;
    settle();
    chk("t4_pop_arrdy", 32'(bus.m_ARREADY_o),  32'd0);
    chk("t4_pop_sa",    32'(bus.sa_ARVALID_o), 32'd0);
    tick();
    bus.m_RVALID_i = 1'b0;
    bus.m_RREADY_i = 1'b0;
    bus.m_RLAST_i  = 1'b0;
    settle();
    chk("t4_cnt7",       32'(bus.outst_cnt_o),  32'd7);
    chk("t4_resume_rdy", 32'(bus.m_ARREADY_o),  32'd1);
    chk("t4_resume_sa",  32'(bus.sa_ARVALID_o), 32'h1);
    tick();
    bus.m_ARVALID_i = 1'b0;
    settle();
    chk("t4_cnt8_again", 32'(bus.outst_cnt_o), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_id = (i % 2 == 0) ? 1'b1 : 1'b0;
      chk("t4_drain_id", 32'(bus.dsp_AR_slv_id_o), 32'(exp_id));
      r_beat(1'b1);
    end
    chk("t4_drained_dis", 32'(bus.dsp_AR_disable_o), 32'd1);
    chk("t4_drained_cnt", 32'(bus.outst_cnt_o),      32'd0);

    // Simultaneous push and pop at count 3.
    ar_push(1'b1, 8'd0);
    ar_push(1'b0, 8'd0);
    ar_push(1'b1, 8'd0);
    chk("t5_cnt3",  32'(bus.outst_cnt_o),     32'd3);
    chk("t5_head1", 32'(bus.dsp_AR_slv_id_o), 32'd1);
    bus.m_ARVALID_i = 1'b1;
    bus.ar_slv_id_i = 1'b0;
    bus.m_RVALID_i  = 1'b1;
    bus.m_RREADY_i  = 1'b1;
    bus.m_RLAST_i   = 1'b1;
    tick();
    bus.m_ARVALID_i = 1'b0;
    bus.m_RVALID_i  = 1'b0;
    bus.m_RREADY_i  = 1'b0;
    bus.m_RLAST_i   = 1'b0;
    settle();
    chk("t5_cnt_hold", 32'(bus.outst_cnt_o),     32'd3);
    chk("t5_head_adv", 32'(bus.dsp_AR_slv_id_o), 32'd0);
    r_beat(1'b1);
    chk("t5_head_b", 32'(bus.dsp_AR_slv_id_o), 32'd1);
    r_beat(1'b1);
    chk("t5_head_c", 32'(bus.dsp_AR_slv_id_o), 32'd0);
    r_beat(1'b1);
    chk("t5_empty", 32'(bus.dsp_AR_disable_o), 32'd1);

    // RLAST handshake while empty is ignored.
    r_beat(1'b1);
    chk("empty_pop_cnt", 32'(bus.outst_cnt_o),      32'd0);
    chk("empty_pop_dis", 32'(bus.dsp_AR_disable_o), 32'd1);

    // Twenty sequential transactions walk the pointers around several times.
    for (int i = 0; i < 20; i++) begin
      exp_id = SLV_ID_W'(((i >> 1) ^ i) & 1);
      ar_push(exp_id, 8'd0);
      chk("wrap_id",  32'(bus.dsp_AR_slv_id_o),  32'(exp_id));
      chk("wrap_cnt", 32'(bus.outst_cnt_o),      32'd1);
      r_beat(1'b1);
      chk("wrap_dis", 32'(bus.dsp_AR_disable_o), 32'd1);
    end
    chk("no_err_yet", 32'(bus.rlast_err_o), 32'd0);

    // Asynchronous reset mid-operation.
    ar_push(1'b1, 8'd0);
    ar_push(1'b0, 8'd0);
    chk("mid_cnt2", 32'(bus.outst_cnt_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.outst_cnt_o),      32'd0);
    chk("mid_rst_dis", 32'(bus.dsp_AR_disable_o), 32'd1);
    chk("mid_rst_id",  32'(bus.dsp_AR_slv_id_o),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    ar_push(1'b1, 8'd0);
    chk("post_rst_id",  32'(bus.dsp_AR_slv_id_o), 32'd1);
    chk("post_rst_cnt", 32'(bus.outst_cnt_o),     32'd1);
    r_beat(1'b1);

    // ARLEN=1 but RLAST on the first beat.
    ar_push(1'b0, 8'd1);
    r_beat(1'b1);
    chk("len_cnt", 32'(bus.outst_cnt_o), 32'd0);
`ifdef DSP_RD_BEAT_CHECK_EN
    chk("len_err_set", 32'(bus.rlast_err_o), 32'd1);
    ar_push(1'b1, 8'd0);
    r_beat(1'b1);
    chk("len_err_sticky", 32'(bus.rlast_err_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("len_err_rst", 32'(bus.rlast_err_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
`else
    chk("len_err_tied", 32'(bus.rlast_err_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
